// File: rtl/branch_resolve_unit_pkg.sv
// Shared branch-resolution definitions: condition codes, predictor counter reset value
// and the saturating counter step. Used by branch_cond_eval and branch_resolve_unit.
package branch_resolve_unit_pkg;

  typedef enum logic [2:0] {
    COND_NEVER = 3'b000,
    COND_JUMP  = 3'b001,
    COND_BEZ   = 3'b010,
    COND_BNE   = 3'b011,
    COND_BEQ   = 3'b100,
    COND_BLT   = 3'b101,
    COND_BGE   = 3'b110,
    COND_BLTU  = 3'b111
  } br_cond_e;

  localparam logic [1:0] CTR_RESET = 2'b01;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? ctr : ctr + 2'd1;
    return (ctr == 2'b00) ? ctr : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator: full-width compares of two operands,
// signed codes in two's complement.
module branch_cond_eval
  import branch_resolve_unit_pkg::*;
#(
  parameter int MAX_LENGTH = 32
) (
  input  logic [2:0]            cond,
  input  logic [MAX_LENGTH-1:0] r1,
  input  logic [MAX_LENGTH-1:0] r2,
  output logic                  taken
);

  logic signed [MAX_LENGTH-1:0] s1;
  logic signed [MAX_LENGTH-1:0] s2;

  assign s1 = r1;
  assign s2 = r2;

  always_comb begin
    taken = 1'b0;
    case (br_cond_e'(cond))
      COND_NEVER: taken = 1'b0;
      COND_JUMP:  taken = 1'b1;
      COND_BEZ:   taken = (r1 == '0);
      COND_BNE:   taken = (r1 != r2);
      COND_BEQ:   taken = (r1 == r2);
      COND_BLT:   taken = (s1 < s2);
      COND_BGE:   taken = (s1 >= s2);
      COND_BLTU:  taken = (r1 < r2);
      default:    taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution with a 2-bit saturating-counter predictor table.
// Predictor table is built only when BRANCH_PREDICT_EN is defined; otherwise static not-taken.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int MAX_LENGTH = 32,
  parameter int PC_WIDTH   = 32,
  parameter int BHT_DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PC_WIDTH-1:0]   pred_pc,
  output logic                  pred_taken,
  input  logic                  br_valid,
  input  logic [2:0]            br_cond,
  input  logic [PC_WIDTH-1:0]   br_pc,
  input  logic                  br_pred_taken,
  input  logic [MAX_LENGTH-1:0] registerval1,
  input  logic [MAX_LENGTH-1:0] registerval2,
  input  logic                  stall,
  output logic                  res_valid,
  output logic                  branch_taken,
  output logic                  mispredict
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic taken_p0;
  logic pred_bit_p0;
  logic accept_p0;
  logic shadow;

  branch_cond_eval #(.MAX_LENGTH(MAX_LENGTH)) u_eval (
    .cond  (br_cond),
    .r1    (registerval1),
    .r2    (registerval2),
    .taken (taken_p0)
  );

  // The wrong-path shadow is exactly the cycle in which the mispredict pulse is shown.
  assign shadow    = mispredict;
  assign accept_p0 = br_valid & ~stall & ~shadow;

`ifdef BRANCH_PREDICT_EN
  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] br_idx;
  logic [1:0]       bht [BHT_DEPTH];
  logic             unused_pc_bits;

  assign pred_idx    = pred_pc[IDX_W+1:2];
  assign br_idx      = br_pc[IDX_W+1:2];
  assign pred_taken  = bht[pred_idx][1];
  assign pred_bit_p0 = br_pred_taken;
  assign unused_pc_bits = ^{pred_pc[PC_WIDTH-1:IDX_W+2], pred_pc[1:0],
                            br_pc[PC_WIDTH-1:IDX_W+2], br_pc[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= CTR_RESET;
    end else if (accept_p0 && (br_cond != COND_NEVER)) begin
      bht[br_idx] <= ctr_next(bht[br_idx], taken_p0);
    end
  end
`else
  logic unused_pred_inputs;

  assign pred_taken  = 1'b0;
  assign pred_bit_p0 = 1'b0;
  assign unused_pred_inputs = ^{pred_pc, br_pc, br_pred_taken};
`endif

  // p0 -> p1: registered resolution outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid    <= 1'b0;
      branch_taken <= 1'b0;
      mispredict   <= 1'b0;
    end else begin
      res_valid  <= accept_p0;
      mispredict <= accept_p0 & (taken_p0 ^ pred_bit_p0);
      if (accept_p0) branch_taken <= taken_p0;
    end
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Next-generation branch resolution block for the execute stage. It evaluates an extended, parametrised set of branch conditions on two register operands and registers the outcome. It keeps a table of 2-bit saturating counters that gives fetch a taken/not-taken prediction, and it raises a one-cycle mispredict pulse so the pipeline can flush and redirect.

## Interface
Parameters:
- MAX_LENGTH, 32, operand width in bits
- PC_WIDTH, 32, program-counter width
- BHT_DEPTH, 16, number of predictor entries; power of two, 2 to 256

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- pred_pc  in  PC_WIDTH  fetch-stage PC for prediction lookup
- pred_taken  out  1  combinational prediction for pred_pc
- br_valid  in  1  a branch or jump occupies execute this cycle
- br_cond  in  3  condition code
- br_pc  in  PC_WIDTH  PC of the resolving branch
- br_pred_taken  in  1  prediction carried down the pipe with the branch
- registerval1, registerval2  in  MAX_LENGTH  operands
- stall  in  1  execute stage frozen this cycle
- res_valid  out  1  registered: a resolution is presented
- branch_taken  out  1  registered resolved direction
- mispredict  out  1  registered one-cycle flush/redirect pulse

## Operation
- Condition codes:
  - 000 NEVER (0)
  - 001 JUMP (1)
  - 010 BEZ (r1==0)
  - 011 BNE (r1!=r2)
  - 100 BEQ (r1==r2)
  - 101 BLT (signed r1<r2)
  - 110 BGE (signed r1>=r2)
  - 111 BLTU (unsigned r1<r2)
- Operands are compared at full MAX_LENGTH. Signed codes use two's complement.
- Table index = br_pc / pred_pc bits [log2(BHT_DEPTH)+1 : 2]. No tags, so aliasing is permitted.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. pred_taken = MSB of the indexed counter.
- Accept condition: br_valid & !stall & !shadow.
- On an accepted branch:
  - capture taken = eval(br_cond);
  - mispredict = taken ^ br_pred_taken;
  - if br_cond != NEVER, update the counter: +1 if taken, −1 if not, saturating at 00 and 11.
- Shadow: the cycle after mispredict=1, br_valid is ignored. That branch is wrong-path: no output, no table update. The shadow is cleared by any cycle without mispredict.
- When br_valid=0, stall=1, or the shadow is active:
  - res_valid=0 and mispredict=0 next cycle;
  - branch_taken holds its value.

## Timing
- Resolution latency is 1 cycle: the edge that accepts br_valid produces res_valid, branch_taken and mispredict in the following cycle.
- pred_taken is a same-cycle combinational read. A read and an update to the same index in the same cycle returns the pre-update counter; the new value is visible next cycle.
- Reset:
  - res_valid=0, branch_taken=0, mispredict=0, shadow=0;
  - all counters = 01 in the same edge.
- Reset asserted mid-operation overrides any simultaneous accept and update.
- A stall during the cycle after a mispredict does not extend the shadow; the shadow lasts exactly one cycle.

## Configuration
- BRANCH_PREDICT_EN defined:
  - predictor table present as described.
- Not defined:
  - no table storage;
  - pred_taken tied 0 (static not-taken);
  - br_pred_taken ignored and treated as 0, so mispredict = taken on every accepted branch, JUMP included;
  - shadow behaviour unchanged.

## Structure
- Condition-code constants (NEVER…BLTU) and the counter reset value (01) belong in the shared defines/package beside the existing branch condition constants.
- The combinational evaluator is a sub-module, branch_cond_eval: cond, r1, r2 → taken.
- The table, shadow flag and output registers live in the top module.

## Test plan
- Reset, then pred_pc=0x40 -> pred_taken=0. One accepted BNE at br_pc=0x40 with r1=5, r2=7, br_pred_taken=0:
  - next cycle res_valid=1, branch_taken=1, mispredict=1;
  - the cycle after, pred_taken for 0x40 (and its alias 0x00, BHT_DEPTH=16) = 1.
- BLT vs BLTU with r1=0xFFFFFFFF, r2=1:
  - BLT: branch_taken=1;
  - BLTU: branch_taken=0.
- Four taken BEQ at one PC drive the counter to 11. Three not-taken then give 00. A fourth not-taken leaves 00; check pred_taken after each.
- Mispredict on branch A with br_valid=1 in the following cycle (branch B, JUMP):
  - B produces no res_valid;
  - B's counter is unchanged.
- br_valid=1 with stall=1 -> res_valid=0, mispredict=0, counter unchanged, branch_taken holds.
- rst=1 in the same cycle as an accepted branch:
  - all outputs 0 next cycle;
  - every counter = 01.
